// File: rtl/hazard_stall_unit_pkg.sv
// Shared encodings for the hazard/stall unit: FSM states, forward selects
// and the forwarding priority rule used by forward_unit.
package hazard_stall_unit_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERR      = 2'd2
    } state_e;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b10;
    localparam logic [1:0] FWD_WB  = 2'b01;

    localparam int WAIT_W = 8;

    // EX/MEM wins over MEM/WB because it holds the younger result; $zero never forwards.
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] src,
        input logic [4:0] mem_dst,
        input logic       mem_we,
        input logic [4:0] wb_dst,
        input logic       wb_we
    );
        if (mem_we && (mem_dst != 5'd0) && (mem_dst == src)) return FWD_MEM;
        if (wb_we && (wb_dst != 5'd0) && (wb_dst == src))    return FWD_WB;
        return FWD_RF;
    endfunction

endpackage

// File: rtl/hazard_stall_unit_forward_unit.sv
// Combinational EX-stage operand forwarding select for both ALU operands.
module forward_unit
    import hazard_stall_unit_pkg::*;
(
    input  logic [4:0] idex_rs_i,
    input  logic [4:0] idex_rt_i,
    input  logic [4:0] exmem_dst_i,
    input  logic       exmem_reg_write_i,
    input  logic [4:0] memwb_dst_i,
    input  logic       memwb_reg_write_i,
    output logic [1:0] forward_a_o,
    output logic [1:0] forward_b_o
);

    assign forward_a_o = fwd_sel(idex_rs_i, exmem_dst_i, exmem_reg_write_i,
                                 memwb_dst_i, memwb_reg_write_i);
    assign forward_b_o = fwd_sel(idex_rt_i, exmem_dst_i, exmem_reg_write_i,
                                 memwb_dst_i, memwb_reg_write_i);

endmodule

// File: rtl/hazard_stall_unit.sv
// 5-stage pipeline hazard/stall sequencer with data-memory wait watchdog.
// Define STALL_CNT_EN to build the saturating stall-cycle counter.
module hazard_stall_unit
    import hazard_stall_unit_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       ifid_rs,
    input  logic [4:0]       ifid_rt,
    input  logic             ifid_uses_rt,
    input  logic [4:0]       idex_rs,
    input  logic [4:0]       idex_rt,
    input  logic [4:0]       idex_dst,
    input  logic             idex_mem_read,
    input  logic [4:0]       exmem_dst,
    input  logic             exmem_reg_write,
    input  logic [4:0]       memwb_dst,
    input  logic             memwb_reg_write,
    input  logic             branch_flush,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic             pipe_hold,
    output logic             memwb_bubble,
    output logic [1:0]       forward_a,
    output logic [1:0]       forward_b,
    output logic             mem_error,
    output logic [CNT_W-1:0] stall_cycles
);

    state_e            state_q;
    logic [WAIT_W-1:0] wait_q;
    logic              mem_stall;
    logic              lu_stall;
    logic [1:0]        fwd_a_raw;
    logic [1:0]        fwd_b_raw;

    forward_unit u_forward_unit (
        .idex_rs_i         (idex_rs),
        .idex_rt_i         (idex_rt),
        .exmem_dst_i       (exmem_dst),
        .exmem_reg_write_i (exmem_reg_write),
        .memwb_dst_i       (memwb_dst),
        .memwb_reg_write_i (memwb_reg_write),
        .forward_a_o       (fwd_a_raw),
        .forward_b_o       (fwd_b_raw)
    );

    assign mem_stall = (mem_req & ~mem_ready) | (state_q == ERR);
    assign lu_stall  = idex_mem_read && (idex_dst != 5'd0) &&
                       ((idex_dst == ifid_rs) || (ifid_uses_rt && (idex_dst == ifid_rt)));
    assign mem_error = (state_q == ERR);

    // NOTE: every output gets a default before the priority chain so no path leaves one unassigned (no latch).
    always_comb begin
        pc_write     = 1'b1;
        ifid_write   = 1'b1;
        ifid_flush   = 1'b0;
        idex_bubble  = 1'b0;
        pipe_hold    = 1'b0;
        memwb_bubble = 1'b0;
        forward_a    = fwd_a_raw;
        forward_b    = fwd_b_raw;
        if (rst) begin
            // Flush the whole pipe to NOPs while reset is held.
            pc_write     = 1'b0;
            ifid_write   = 1'b0;
            ifid_flush   = 1'b1;
            idex_bubble  = 1'b1;
            memwb_bubble = 1'b1;
            forward_a    = FWD_RF;
            forward_b    = FWD_RF;
        end else if (mem_stall) begin
            // A pending branch_flush is dropped; the held ID instruction re-asserts it.
            pc_write     = 1'b0;
            ifid_write   = 1'b0;
            pipe_hold    = 1'b1;
            memwb_bubble = 1'b1;
        end else if (lu_stall) begin
            pc_write     = 1'b0;
            ifid_write   = 1'b0;
            idex_bubble  = 1'b1;
        end else if (branch_flush) begin
            ifid_flush   = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            wait_q  <= '0;
        end else begin
            unique case (state_q)
                RUN: begin
                    if (mem_stall) begin
                        state_q <= MEM_WAIT;
                        wait_q  <= WAIT_W'(1);
                    end
                end
                MEM_WAIT: begin
                    // mem_ready is tested first so it beats the timeout compare.
                    if (mem_ready || !mem_req) begin
                        state_q <= RUN;
                        wait_q  <= '0;
                    end else if (wait_q == WAIT_W'(MEM_TIMEOUT)) begin
                        state_q <= ERR;
                    end else begin
                        wait_q  <= wait_q + WAIT_W'(1);
                    end
                end
                ERR:     state_q <= ERR;
                default: begin
                    state_q <= RUN;
                    wait_q  <= '0;
                end
            endcase
        end
    end

`ifdef STALL_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else if ((mem_stall || lu_stall) && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_q <= stall_cnt_q + CNT_W'(1);
        end
    end

    assign stall_cycles = stall_cnt_q;
`else
    assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Self-checking bench for hazard_stall_unit: directed steps then random vectors
// against a cycle-level behavioural model of the stall/forward rules.
module tb_hazard_stall_unit;

    localparam int T  = 4;
    localparam int CW = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic [4:0]    ifid_rs, ifid_rt, idex_rs, idex_rt, idex_dst, exmem_dst, memwb_dst;
    logic          ifid_uses_rt, idex_mem_read, exmem_reg_write, memwb_reg_write;
    logic          branch_flush, mem_req, mem_ready;
    logic          pc_write, ifid_write, ifid_flush, idex_bubble, pipe_hold, memwb_bubble;
    logic [1:0]    forward_a, forward_b;
    logic          mem_error;
    logic [CW-1:0] stall_cycles;

    int n_vec  = 0;
    int n_miss = 0;

    // Model: error flag, run length of consecutive raw memory stalls, stall count.
    bit m_known  = 1'b0;
    bit m_err    = 1'b0;
    int m_consec = 0;
    int m_cnt    = 0;

    hazard_stall_unit #(.MEM_TIMEOUT(T), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .ifid_rs(ifid_rs), .ifid_rt(ifid_rt), .ifid_uses_rt(ifid_uses_rt),
        .idex_rs(idex_rs), .idex_rt(idex_rt), .idex_dst(idex_dst),
        .idex_mem_read(idex_mem_read),
        .exmem_dst(exmem_dst), .exmem_reg_write(exmem_reg_write),
        .memwb_dst(memwb_dst), .memwb_reg_write(memwb_reg_write),
        .branch_flush(branch_flush), .mem_req(mem_req), .mem_ready(mem_ready),
        .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
        .idex_bubble(idex_bubble), .pipe_hold(pipe_hold), .memwb_bubble(memwb_bubble),
        .forward_a(forward_a), .forward_b(forward_b),
        .mem_error(mem_error), .stall_cycles(stall_cycles)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] ref_fwd(input logic [4:0] src);
        if (exmem_reg_write && exmem_dst != 0 && exmem_dst == src) return 2'b10;
        if (memwb_reg_write && memwb_dst != 0 && memwb_dst == src) return 2'b01;
        return 2'b00;
    endfunction

    function automatic int exp_count();
`ifdef STALL_CNT_EN
        return m_cnt;
`else
        return 0;
`endif
    endfunction

    task automatic set_idle();
        rst = 1'b0; ifid_rs = 0; ifid_rt = 0; ifid_uses_rt = 1'b0;
        idex_rs = 0; idex_rt = 0; idex_dst = 0; idex_mem_read = 1'b0;
        exmem_dst = 0; exmem_reg_write = 1'b0; memwb_dst = 0; memwb_reg_write = 1'b0;
        branch_flush = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
    endtask

    // Check all outputs mid-cycle, then advance the model across the rising edge.
    task automatic tick();
        bit raw, ms, lu;
        logic e_pc, e_ifw, e_iff, e_idb, e_ph, e_mwb;
        @(negedge clk);
        raw = mem_req && !mem_ready;
        ms  = raw || m_err;
        lu  = idex_mem_read && idex_dst != 0 &&
              (idex_dst == ifid_rs || (ifid_uses_rt && idex_dst == ifid_rt));
        {e_pc, e_ifw, e_iff, e_idb, e_ph, e_mwb} = 6'b110000;
        if (rst)               {e_pc, e_ifw, e_iff, e_idb, e_ph, e_mwb} = 6'b001101;
        else if (ms)           {e_pc, e_ifw, e_iff, e_idb, e_ph, e_mwb} = 6'b000011;
        else if (lu)           {e_pc, e_ifw, e_iff, e_idb, e_ph, e_mwb} = 6'b000100;
        else if (branch_flush) {e_pc, e_ifw, e_iff, e_idb, e_ph, e_mwb} = 6'b111000;
        chk("pc_write",     32'(pc_write),     32'(e_pc));
        chk("ifid_write",   32'(ifid_write),   32'(e_ifw));
        chk("ifid_flush",   32'(ifid_flush),   32'(e_iff));
        chk("idex_bubble",  32'(idex_bubble),  32'(e_idb));
        chk("pipe_hold",    32'(pipe_hold),    32'(e_ph));
        chk("memwb_bubble", 32'(memwb_bubble), 32'(e_mwb));
        chk("forward_a",    32'(forward_a),    rst ? 32'd0 : 32'(ref_fwd(idex_rs)));
        chk("forward_b",    32'(forward_b),    rst ? 32'd0 : 32'(ref_fwd(idex_rt)));
        if (m_known) begin
            chk("mem_error",    32'(mem_error),    32'(m_err));
            chk("stall_cycles", 32'(stall_cycles), 32'(exp_count()));
        end
        @(posedge clk);
        if (rst) begin
            m_known = 1'b1; m_err = 1'b0; m_consec = 0; m_cnt = 0;
        end else begin
            if ((ms || lu) && m_cnt < (1 << CW) - 1) m_cnt++;
            if (!m_err) begin
                if (raw) begin
                    m_consec++;
                    if (m_consec > T) m_err = 1'b1;
                end else begin
                    m_consec = 0;
                end
            end
        end
        #1;
    endtask

    initial begin
        set_idle();
        rst = 1'b1; idex_rs = 5'd5; exmem_dst = 5'd5; exmem_reg_write = 1'b1;
        tick(); tick();
        set_idle();
        tick();

        // Forwarding priority and $zero suppression.
        exmem_dst = 5'd5; exmem_reg_write = 1'b1; memwb_dst = 5'd5; memwb_reg_write = 1'b1;
        idex_rs = 5'd5; idex_rt = 5'd5;
        tick();
        chk("fwd_a_exmem", 32'(forward_a), 32'h2);
        exmem_dst = 5'd0;
        tick();
        chk("fwd_a_memwb", 32'(forward_a), 32'h1);
        set_idle();

        // Load-use: one bubble, then EX holds a NOP and the pipe runs.
        idex_mem_read = 1'b1; idex_dst = 5'd8; ifid_rs = 5'd8;
        tick();
        idex_mem_read = 1'b0; idex_dst = 5'd0;
        tick();
        chk("lu_release", 32'(pc_write), 32'h1);
        ifid_rs = 5'd3; ifid_rt = 5'd8; ifid_uses_rt = 1'b0; idex_mem_read = 1'b1; idex_dst = 5'd8;
        tick();
        chk("lu_rt_unused", 32'(idex_bubble), 32'h0);
        ifid_uses_rt = 1'b1;
        tick();
        set_idle();

        // Three memory wait cycles from a clean counter.
        rst = 1'b1; tick(); rst = 1'b0;
        mem_req = 1'b1;
        repeat (3) tick();
        mem_ready = 1'b1;
        tick();
`ifdef STALL_CNT_EN
        chk("stall_cnt_3", 32'(stall_cycles), 32'd3);
`else
        chk("stall_cnt_3", 32'(stall_cycles), 32'd0);
`endif

        // Branch flush suppressed under a memory stall, then taken when it ends.
        mem_ready = 1'b0; branch_flush = 1'b1;
        repeat (2) tick();
        mem_ready = 1'b1;
        tick();
        chk("flush_after_stall", 32'(ifid_flush), 32'h1);
        set_idle();
        tick();

        // Watchdog: hang the memory, error is sticky until reset.
        mem_req = 1'b1;
        repeat (8) tick();
        chk("err_set", 32'(mem_error), 32'h1);
        mem_req = 1'b0;
        tick();
        chk("err_sticky", 32'(mem_error), 32'h1);
        rst = 1'b1; tick(); rst = 1'b0;
        tick();
        chk("err_cleared", 32'(mem_error), 32'h0);

        // Counter saturation with 20 load-use stall cycles.
        idex_mem_read = 1'b1; idex_dst = 5'd9; ifid_rs = 5'd9;
        repeat (20) tick();
`ifdef STALL_CNT_EN
        chk("stall_cnt_sat", 32'(stall_cycles), 32'd15);
`else
        chk("stall_cnt_sat", 32'(stall_cycles), 32'd0);
`endif
        set_idle();

        // Random traffic on a small register set so hazards collide often.
        for (int i = 0; i < 400; i++) begin
            rst             = ($urandom_range(0, 99) < 3);
            ifid_rs         = 5'($urandom_range(0, 3));
            ifid_rt         = 5'($urandom_range(0, 3));
            ifid_uses_rt    = 1'($urandom_range(0, 1));
            idex_rs         = 5'($urandom_range(0, 3));
            idex_rt         = 5'($urandom_range(0, 3));
            idex_dst        = 5'($urandom_range(0, 3));
            idex_mem_read   = 1'($urandom_range(0, 1));
            exmem_dst       = 5'($urandom_range(0, 3));
            exmem_reg_write = 1'($urandom_range(0, 1));
            memwb_dst       = 5'($urandom_range(0, 3));
            memwb_reg_write = 1'($urandom_range(0, 1));
            branch_flush    = ($urandom_range(0, 99) < 25);
            mem_req         = ($urandom_range(0, 99) < 60);
            mem_ready       = ($urandom_range(0, 99) < 30);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/hazard_stall_unit.md
Name: hazard_stall_unit

Overview:
- Sequences the 5-stage MIPS pipeline around the main decoder: EX-operand forwarding, load-use stalls, stalls for variable-latency data memory, and the ID-stage branch/jump flush.
- Drives the write-enable, flush and bubble controls of PC, IF/ID, ID/EX, EX/MEM and MEM/WB.
- Detects a hung data memory with a wait-cycle watchdog.

Parameters:
- MEM_TIMEOUT, 15, max consecutive cycles in MEM_WAIT before ERR (1..255).
- CNT_W, 16, width of the stall-cycle counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- ifid_rs, ifid_rt  in  5 each  source registers of the instruction in ID.
- ifid_uses_rt  in  1  ID instruction reads rt (R-type, BEQ, BNE, SW).
- idex_rs, idex_rt  in  5 each  source registers of the instruction in EX.
- idex_dst  in  5  EX destination register.
- idex_mem_read  in  1  EX instruction is a LW.
- exmem_dst  in  5  MEM destination register.
- exmem_reg_write  in  1  MEM instruction writes a register.
- memwb_dst  in  5  WB destination register.
- memwb_reg_write  in  1  WB instruction writes a register.
- branch_flush  in  1  decoder flush (taken BEQ/BNE, J, JAL, JR).
- mem_req  in  1  MEM stage accesses data memory.
- mem_ready  in  1  data memory completes this cycle.
- pc_write  out  1  PC update enable.
- ifid_write  out  1  IF/ID enable.
- ifid_flush  out  1  IF/ID load NOP.
- idex_bubble  out  1  ID/EX load NOP.
- pipe_hold  out  1  hold ID/EX and EX/MEM.
- memwb_bubble  out  1  MEM/WB load NOP.
- forward_a, forward_b  out  2 each  ALU operand select: 00 regfile, 10 EX/MEM, 01 MEM/WB.
- mem_error  out  1  sticky watchdog flag.
- stall_cycles  out  CNT_W  saturating stall counter.

Behaviour:
- Forwarding is combinational.
  - forward_a = 10 if exmem_reg_write, exmem_dst≠0 and exmem_dst==idex_rs.
  - Otherwise 01 if memwb_reg_write, memwb_dst≠0 and memwb_dst==idex_rs.
  - Otherwise 00. EX/MEM has priority over MEM/WB.
  - forward_b uses the same rules with idex_rt.
- Terms:
  - mem_stall = mem_req & ~mem_ready, or state==ERR.
  - lu_stall = idex_mem_read & idex_dst≠0 & (idex_dst==ifid_rs | (ifid_uses_rt & idex_dst==ifid_rt)).
- Control priority is mem_stall, then lu_stall, then branch_flush.
  - mem_stall: pc_write=0, ifid_write=0, pipe_hold=1, memwb_bubble=1, ifid_flush=0, idex_bubble=0. branch_flush is ignored; the held ID instruction re-asserts it.
  - lu_stall: pc_write=0, ifid_write=0, idex_bubble=1, ifid_flush=0. Exactly one bubble; the next cycle EX holds the NOP, so the stall does not recur.
  - branch_flush: pc_write=1, ifid_write=1, ifid_flush=1.
  - None of the above: all enables 1, all flush/bubble/hold 0.
- FSM states RUN, MEM_WAIT, ERR.
  - RUN→MEM_WAIT when mem_stall; the wait counter loads 1.
  - MEM_WAIT→RUN when mem_ready, or when mem_req drops. The counter clears.
  - MEM_WAIT with mem_stall: counter increments.
  - MEM_WAIT→ERR when counter==MEM_TIMEOUT and mem_stall persists.
  - ERR is absorbing until rst. The pipeline is frozen (mem_stall=1) and mem_error=1.
- mem_ready arriving in the same cycle as the timeout compare: ready wins and the FSM returns to RUN.
- stall_cycles increments on every cycle with mem_stall or lu_stall and saturates at all-ones.
- Reset (also mid-MEM_WAIT or in ERR), at the next edge:
  - State RUN, wait counter 0, mem_error 0, stall_cycles 0.
  - While rst is high: pc_write=0, ifid_write=0, ifid_flush=1, idex_bubble=1, memwb_bubble=1, pipe_hold=0, forward_a/forward_b=00.

Optional Feature:
- STALL_CNT_EN defined: stall_cycles is live as described.
- Undefined: no counter register; stall_cycles is tied to 0. All other behaviour is identical.

Decomposition:
- Shared package holds:
  - FSM state encoding: RUN=0, MEM_WAIT=1, ERR=2.
  - Forward select constants: FWD_RF=00, FWD_MEM=10, FWD_WB=01.
- One sub-module, forward_unit: purely combinational, computes forward_a/forward_b.
- FSM, stall logic and counters stay in the top module.

Test Plan:
- EX/MEM dst=5 write=1, MEM/WB dst=5 write=1, idex_rs=5 → forward_a=10. Repeat with exmem_dst=0 → forward_a=01.
- idex_mem_read=1, idex_dst=8, ifid_rs=8 → one cycle of pc_write=0 and idex_bubble=1, then normal operation. Repeat with ifid_uses_rt=0 and ifid_rt=8 only → no stall.
- mem_req=1 with mem_ready low for 3 cycles → pipe_hold=1 for those 3 cycles and FSM in MEM_WAIT. mem_ready high → RUN; stall_cycles=3.
- branch_flush=1 together with a mem stall → ifid_flush=0. Stall ends with branch_flush still 1 → ifid_flush=1 for one cycle.
- MEM_TIMEOUT=4, mem_ready held low → mem_error=1 after the 4th wait cycle and stays set. rst for one cycle → mem_error=0, state RUN.
- STALL_CNT_EN undefined with repeated stalls → stall_cycles stays 0. With CNT_W=4 and the macro defined, 20 stalls → saturates at 15.
